// File: rtl/fp_argmax_classifier_if.sv
// rtl/fp_argmax_classifier_if.sv - score stream in / winning class out bundle for the argmax classifier
interface fp_argmax_classifier_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic [31:0]      cos_theta;
  logic             cos_valid;
  logic [IDX_W-1:0] class_idx;
  logic [31:0]      best_cos;
  logic             class_valid;
  logic             busy;

  modport master (
    output start, cos_theta, cos_valid,
    input  class_idx, best_cos, class_valid, busy
  );

  modport slave (
    input  start, cos_theta, cos_valid,
    output class_idx, best_cos, class_valid, busy
  );
endinterface

// File: rtl/fp_argmax_classifier.sv
// rtl/fp_argmax_classifier.sv - picks the largest IEEE-754 cosine score of NUM_CLASSES, skipping NaNs
module fp_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_argmax_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_restart;
  logic             w_consume;
  logic             w_last;
  logic             w_is_nan;
  logic             w_take;

  logic [IDX_W-1:0] r_cnt;
  logic             r_have;
  logic [31:0]      r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_class_idx;
  logic [31:0]      r_best_cos;

  // Total order on non-NaN floats; +0 and -0 compare equal.
  function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
    logic w_res;
    w_res = 1'b0;
    case ({a[31], b[31]})
      2'b00:   w_res = (a[30:0] > b[30:0]);
      2'b01:   w_res = ((a[30:0] | b[30:0]) != 31'd0);
      2'b10:   w_res = 1'b0;
      default: w_res = (a[30:0] < b[30:0]);
    endcase
    return w_res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_consume   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_COLLECT;
          w_restart   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (bus.start) begin
          w_restart = 1'b1;
        end else if (bus.cos_valid) begin
          w_consume = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_is_nan = (bus.cos_theta[30:23] == 8'hFF) && (bus.cos_theta[22:0] != 23'd0);
  assign w_take   = w_consume && !w_is_nan && (!r_have || f_gt(bus.cos_theta, r_best));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_have      <= 1'b0;
      r_best      <= 32'd0;
      r_best_idx  <= '0;
      r_class_idx <= '0;
      r_best_cos  <= 32'd0;
    end else if (w_restart) begin
      r_cnt      <= '0;
      r_have     <= 1'b0;
      r_best     <= 32'd0;
      r_best_idx <= '0;
    end else if (w_consume) begin
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      if (w_take) begin
        r_best     <= bus.cos_theta;
        r_best_idx <= r_cnt;
        r_have     <= 1'b1;
      end
      // Result registers fold in the final score so they are valid during DONE.
      if (w_last) begin
        if (w_take) begin
          r_class_idx <= r_cnt;
          r_best_cos  <= bus.cos_theta;
        end else if (r_have) begin
          r_class_idx <= r_best_idx;
          r_best_cos  <= r_best;
        end else begin
          r_class_idx <= '0;
          r_best_cos  <= QNAN;
        end
      end
    end
  end

  assign bus.class_idx   = r_class_idx;
  assign bus.best_cos    = r_best_cos;
  assign bus.class_valid = (r_state == S_DONE);
  assign bus.busy        = (r_state == S_COLLECT);

endmodule

// File: tb/tb_fp_argmax_classifier.sv
// tb/tb_fp_argmax_classifier.sv - directed-vector self-checking bench for fp_argmax_classifier
module tb_fp_argmax_classifier;

  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pulses;
  logic [31:0] vec [NUM_CLASSES];

  fp_argmax_classifier_if #(.IDX_W(IDX_W)) bus ();

  fp_argmax_classifier #(.NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.class_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] s);
    bus.cos_theta = s;
    bus.cos_valid = 1'b1;
    step();
    bus.cos_valid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] d);
    for (int i = 0; i < NUM_CLASSES; i++) vec[i] = d;
  endtask

  task automatic send_all();
    for (int i = 0; i < NUM_CLASSES; i++) send(vec[i]);
  endtask

  task automatic expect_result(input string tag, input int idx, input logic [31:0] cos);
    chk({tag, "_cv"},   32'(bus.class_valid), 32'd1);
    chk({tag, "_idx"},  32'(bus.class_idx),   32'(idx));
    chk({tag, "_cos"},  bus.best_cos,         cos);
    chk({tag, "_busy"}, 32'(bus.busy),        32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulses = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cos_valid = 1'b0;
    bus.cos_theta = 32'd0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cv",   32'(bus.class_valid), 32'd0);
    chk("rst_idx",  32'(bus.class_idx), 32'd0);
    chk("rst_cos",  bus.best_cos, 32'd0);
    rst = 1'b0;
    step();

    // Max at last class
    do_start();
    chk("q1_busy", 32'(bus.busy), 32'd1);
    fill(32'h3E80_0000);
    vec[9] = 32'h3F80_0000;
    send_all();
    expect_result("q1", 9, 32'h3F80_0000);
    step();
    chk("q1_cv_off", 32'(bus.class_valid), 32'd0);
    chk("q1_hold",   32'(bus.class_idx), 32'd9);

    // Tie keeps lower index; start in DONE is ignored
    do_start();
    fill(32'hBF00_0000);
    vec[3] = 32'h3F00_0000;
    vec[7] = 32'h3F00_0000;
    send_all();
    expect_result("q2", 3, 32'h3F00_0000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("q2_done_start", 32'(bus.busy), 32'd0);
    chk("q2_cos_hold", bus.best_cos, 32'h3F00_0000);

    // All negative with NaN at class 0
    do_start();
    fill(32'hBF00_0000);
    vec[0] = 32'h7FC0_0000;
    vec[5] = 32'hBE80_0000;
    send_all();
    expect_result("q3", 5, 32'hBE80_0000);
    step();

    // Gapped collection then restart
    pulses = 0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(32'h3F80_0000);
      step();
      chk("q4_gap_busy", 32'(bus.busy), 32'd1);
      step();
    end
    do_start();
    chk("q4_restart_busy", 32'(bus.busy), 32'd1);
    fill(32'h3E80_0000);
    vec[2] = 32'h3F80_0000;
    send_all();
    expect_result("q4", 2, 32'h3F80_0000);
    step();
    chk("q4_pulses", 32'(pulses), 32'd1);

    // All NaN
    do_start();
    fill(32'hFFC0_0001);
    vec[4] = 32'h7F80_0001;
    send_all();
    expect_result("q5", 0, 32'h7FC0_0000);
    step();

    // Signed zeros, denormals, -Inf
    do_start();
    fill(32'h0000_0000);
    vec[0] = 32'h8000_0000;
    vec[2] = 32'h0000_0001;
    vec[3] = 32'h8000_0001;
    vec[4] = 32'hFF80_0000;
    send_all();
    expect_result("q6", 2, 32'h0000_0001);
    step();

    // -0 then +0: equal, class 0 kept
    do_start();
    fill(32'hBF80_0000);
    vec[0] = 32'h8000_0000;
    vec[1] = 32'h0000_0000;
    send_all();
    expect_result("q7", 0, 32'h8000_0000);
    step();

    // +Inf wins
    do_start();
    fill(32'h3F80_0000);
    vec[8] = 32'h7F80_0000;
    send_all();
    expect_result("q8", 8, 32'h7F80_0000);
    step();

    // start and cos_valid together in IDLE: score dropped
    bus.start = 1'b1;
    bus.cos_valid = 1'b1;
    bus.cos_theta = 32'h4000_0000;
    step();
    bus.start = 1'b0;
    bus.cos_valid = 1'b0;
    fill(32'h3E80_0000);
    vec[4] = 32'h3F80_0000;
    send_all();
    expect_result("q9", 4, 32'h3F80_0000);
    step();

    // Reset mid-collection
    pulses = 0;
    do_start();
    for (int i = 0; i < 6; i++) send(32'h3F00_0000);
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("q10_busy", 32'(bus.busy), 32'd0);
    chk("q10_idx",  32'(bus.class_idx), 32'd0);
    chk("q10_cos",  bus.best_cos, 32'd0);
    for (int i = 0; i < 4; i++) send(32'h3F80_0000);
    step();
    chk("q10_pulses", 32'(pulses), 32'd0);

    // Scores without start
    for (int i = 0; i < NUM_CLASSES; i++) begin
      send(32'h3F80_0000);
      chk("q11_busy", 32'(bus.busy), 32'd0);
    end
    step();
    chk("q11_pulses", 32'(pulses), 32'd0);
    chk("q11_idx",    32'(bus.class_idx), 32'd0);
    chk("q11_cos",    bus.best_cos, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_argmax_classifier.md
FP_ARGMAX_CLASSIFIER -- requirements
Module: fp_argmax_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of class cosine scores per query (MNIST digits).
REQ-002 SHALL have parameter IDX_W, default 4, width of class index; SHALL satisfy 2^IDX_W >= NUM_CLASSES.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse opening a new query.
REQ-006 SHALL have port cos_theta  input  32  IEEE-754 single cosine score from FP_Cosine_Similarity.
REQ-007 SHALL have port cos_valid  input  1  cos_theta qualifier, one score per asserted cycle, class order 0..NUM_CLASSES-1.
REQ-008 SHALL have port class_idx  output  IDX_W  index of winning class.
REQ-009 SHALL have port best_cos  output  32  cos_theta of winning class, bit-exact.
REQ-010 SHALL have port class_valid  output  1  one-cycle pulse, class_idx/best_cos valid.
REQ-011 SHALL have port busy  output  1  high while a query is being collected.

Function
REQ-012 SHALL implement FSM IDLE -> COLLECT -> DONE -> IDLE, registered state.
REQ-013 IDLE: start=1 -> COLLECT next cycle, sample counter cleared to 0, running best cleared; cos_valid ignored.
REQ-014 COLLECT: each cos_valid=1 cycle consumes one score, increments counter; cos_valid=0 cycles hold all state (gaps allowed).
REQ-015 COLLECT: score with counter=0 SHALL load unconditionally into best (idx 0), unless NaN.
REQ-016 COLLECT: later score replaces best only if strictly greater; ties keep lower index.
REQ-017 Compare SHALL be IEEE-754 total order on non-NaN values: sign-magnitude, any positive > any negative, larger magnitude wins for positive, smaller magnitude wins for negative; +0 and -0 equal.
REQ-018 NaN (exp=0xFF, mantissa!=0) SHALL never become best; +Inf/-Inf compare normally; denormals compare by raw bits.
REQ-019 If all scores NaN, best_cos SHALL be 0x7FC00000, class_idx 0.
REQ-020 Consumption of score NUM_CLASSES-1 SHALL move FSM to DONE next cycle; class_valid=1 in DONE for exactly one cycle, then IDLE.
REQ-021 Latency: class_valid SHALL assert exactly 1 cycle after the cycle carrying the last cos_valid.
REQ-022 class_idx/best_cos SHALL hold their values after class_valid until the next DONE.
REQ-023 start=1 in COLLECT SHALL abort and restart the query (counter and best cleared, busy stays 1); start in DONE ignored.
REQ-024 start and cos_valid in the same IDLE cycle: score ignored, only start honoured.
REQ-025 busy SHALL be 1 exactly when state=COLLECT.
REQ-026 Counter SHALL be IDX_W bits and never wrap; extra cos_valid beyond NUM_CLASSES is impossible since FSM leaves COLLECT.

Reset
REQ-027 rst=1 at any clock edge, including mid-COLLECT or in DONE, SHALL force IDLE, counter 0, class_idx 0, best_cos 0x00000000, class_valid 0, busy 0 on the next cycle.
REQ-028 rst SHALL dominate start and cos_valid in the same cycle.

Verification
REQ-029 start; scores 0x3E800000 x9 then 0x3F800000 at class 9 -> class_valid one cycle after 10th score, class_idx=9, best_cos=0x3F800000.
REQ-030 start; class 3 = 0x3F000000, class 7 = 0x3F000000, all others 0xBF000000 -> class_idx=3 (tie keeps lower), best_cos=0x3F000000.
REQ-031 start; all scores negative, class 5 = 0xBE800000 (-0.25), others 0xBF000000 -> class_idx=5, best_cos=0xBE800000; class 0 = 0x7FC00000 NaN never chosen.
REQ-032 start; 4 scores with 2-cycle gaps, then start again, then 10 scores with class 2 = 0x3F800000 -> single class_valid, class_idx=2; busy=1 throughout both collections.
REQ-033 rst asserted after 6th score -> next cycle busy=0, class_idx=0, best_cos=0; remaining cos_valid pulses produce no class_valid.
REQ-034 cos_valid pulses with no start -> no class_valid, busy stays 0, outputs unchanged.
